// File: rtl/rr_arb_mux_pkg.sv
// Shared constants and helpers for the arbitrating multiplexer.
// Channel assignment for the datapath requesters lives here.
package rr_arb_mux_pkg;

    localparam int unsigned ARB_CH_IFETCH = 0;
    localparam int unsigned ARB_CH_DMEM   = 1;

    // Channel-index width; a 2-channel mux still needs one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_mux_pick.sv
// Round-robin / fixed-priority picker: lowest requester at or after ptr_i,
// found by a priority search over {req, req & mask}.
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [SELW-1:0] ptr_i,
    input  logic            rr_en_i,
    output logic [SELW-1:0] grant_idx_o,
    output logic            grant_valid_o
);

    logic [N-1:0]   mask;
    logic [2*N-1:0] dbl;
    logic           found;

    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            // Fixed priority behaves as round-robin with ptr pinned at 0.
            mask[i] = ~rr_en_i | (i >= int'(ptr_i));
        end
        dbl           = {req_i, req_i & mask};
        grant_valid_o = |req_i;
        grant_idx_o   = '0;
        found         = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            if (!found && dbl[i]) begin
                found       = 1'b1;
                grant_idx_o = (i >= N) ? SELW'(i - N) : SELW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel arbitrating mux with valid/ready on every port and a one-entry
// registered output stage; holds the round-robin pointer.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = sel_width(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rr_en,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    logic [SELW-1:0]  grant_idx;
    logic             grant_valid;
    logic [WIDTH-1:0] grant_data;
    logic             load;
    logic             accept;

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .req_i         (in_valid),
        .ptr_i         (ptr_q),
        .rr_en_i       (rr_en),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    always_comb begin
        load       = ~valid_q | out_ready;
        accept     = rst_n & load & grant_valid;
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SELW'(i)) begin
                in_ready[i] = accept;
                grant_data  = in_data[i*WIDTH +: WIDTH];
            end
        end

        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            valid_d = accept;
        end
        if (accept) begin
            data_d = grant_data;
            sel_d  = grant_idx;
            ptr_d  = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign out_valid = valid_q;

endmodule
